// File: rtl/ps2_device_port_pkg.sv
// Shared types and constants for the PS/2 device-side port.
// Holds the FSM encoding, the common keyboard byte codes and the TX frame bit helper.
package ps2_device_port_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX_SLOT,
    ST_RX_SLOT,
    ST_RX_ACK,
    ST_DONE
  } ps2_state_t;

  localparam logic [7:0] PS2_ACK      = 8'hFA;
  localparam logic [7:0] PS2_RESEND   = 8'hFE;
  localparam logic [7:0] PS2_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_RELEASE  = 8'hF0;

  // Frame slot 0 is the start bit, 1..8 data LSB first, 9 odd parity, 10 stop.
  function automatic logic tx_bit(input logic [7:0] b, input logic [3:0] idx);
    if (idx == 4'd0)       return 1'b0;
    else if (idx <= 4'd8)  return b[3'(idx - 4'd1)];
    else if (idx == 4'd9)  return ~^b;
    else                   return 1'b1;
  endfunction

endpackage

// File: rtl/ps2_device_port_debounce.sv
// Two-flop synchronizer plus stability filter for one open-drain PS/2 line.
// The output only follows the input after DEBOUNCE_LIMIT consecutive differing samples.
module ps2_device_port_debounce #(
  parameter int DEBOUNCE_LIMIT = 20
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_in,
  output logic o_out
);
  localparam int CW = $clog2(DEBOUNCE_LIMIT + 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;

  // Idle bus level is high, so everything resets to 1.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
      o_out  <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], i_in};
      if (sync_q[1] == o_out) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_LIMIT - 1)) begin
        cnt_q <= '0;
        o_out <= sync_q[1];
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_device_port.sv
// Keyboard end of a PS/2 link: owns the clock, sends device frames, receives host commands.
// Line drivers are open-drain and driven straight from registers.
module ps2_device_port
  import ps2_device_port_pkg::*;
#(
  parameter int HALF_PERIOD = 400,
  parameter int IDLE_HOLD   = 500,
  parameter int FILTER      = 20
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  inout  wire        io_ps2_clk,
  inout  wire        io_ps2_data,
  input  logic [7:0] i_tx_byte,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic       o_tx_done,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_valid,
  output logic       o_rx_parity_err,
  output logic       o_rx_frame_err
);
  localparam int SLOT = 2 * HALF_PERIOD;
  localparam int SW   = $clog2(SLOT);
  localparam int IW   = $clog2(IDLE_HOLD + 1);
  localparam logic [SW-1:0] HP_LAST  = SW'(HALF_PERIOD - 1);
  localparam logic [SW-1:0] SL_LAST  = SW'(SLOT - 1);
  localparam logic [SW-1:0] RX_SAMP  = SW'(HALF_PERIOD + HALF_PERIOD / 2);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_HOLD);

  logic clk_in, data_in;

  ps2_device_port_debounce #(.DEBOUNCE_LIMIT(FILTER)) u_db_clk (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_in(io_ps2_clk), .o_out(clk_in)
  );
  ps2_device_port_debounce #(.DEBOUNCE_LIMIT(FILTER)) u_db_data (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_in(io_ps2_data), .o_out(data_in)
  );

  ps2_state_t    state_q, state_n;
  logic [SW-1:0] slot_q, slot_n;
  logic [3:0]    bit_q, bit_n;
  logic [IW-1:0] idle_q, idle_n;
  logic          held_q, held_n, seen_q, seen_n;
  logic [7:0]    tx_q, tx_n;
  logic [9:0]    rxs_q, rxs_n;
  logic          clk_drv_q, clk_drv_n, data_drv_q, data_drv_n;
  logic          ready_n, done_n, rxv_n, perr_n, ferr_n;
  logic [7:0]    rx_byte_n;

  assign io_ps2_clk  = clk_drv_q  ? 1'b0 : 1'bz;
  assign io_ps2_data = data_drv_q ? 1'b0 : 1'bz;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q         <= ST_IDLE;
      slot_q          <= '0;
      bit_q           <= '0;
      idle_q          <= '0;
      held_q          <= 1'b0;
      seen_q          <= 1'b0;
      tx_q            <= '0;
      rxs_q           <= '0;
      clk_drv_q       <= 1'b0;
      data_drv_q      <= 1'b0;
      o_tx_ready      <= 1'b0;
      o_tx_done       <= 1'b0;
      o_rx_byte       <= '0;
      o_rx_valid      <= 1'b0;
      o_rx_parity_err <= 1'b0;
      o_rx_frame_err  <= 1'b0;
    end else begin
      state_q         <= state_n;
      slot_q          <= slot_n;
      bit_q           <= bit_n;
      idle_q          <= idle_n;
      held_q          <= held_n;
      seen_q          <= seen_n;
      tx_q            <= tx_n;
      rxs_q           <= rxs_n;
      clk_drv_q       <= clk_drv_n;
      data_drv_q      <= data_drv_n;
      o_tx_ready      <= ready_n;
      o_tx_done       <= done_n;
      o_rx_byte       <= rx_byte_n;
      o_rx_valid      <= rxv_n;
      o_rx_parity_err <= perr_n;
      o_rx_frame_err  <= ferr_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    slot_n     = (slot_q == SL_LAST) ? '0 : slot_q + 1'b1;
    bit_n      = bit_q;
    idle_n     = idle_q;
    held_n     = held_q;
    seen_n     = 1'b0;
    tx_n       = tx_q;
    rxs_n      = rxs_q;
    clk_drv_n  = clk_drv_q;
    data_drv_n = data_drv_q;
    done_n     = 1'b0;
    rxv_n      = 1'b0;
    ferr_n     = 1'b0;
    perr_n     = o_rx_parity_err;
    rx_byte_n  = o_rx_byte;

    case (state_q)
      ST_IDLE: begin
        slot_n     = '0;
        bit_n      = '0;
        clk_drv_n  = 1'b0;
        data_drv_n = 1'b0;
        idle_n     = (clk_in && data_in) ? ((idle_q == IDLE_MAX) ? idle_q : idle_q + 1'b1) : '0;
        seen_n     = seen_q | ~clk_in;
        if (i_tx_valid && o_tx_ready) begin
          held_n = 1'b1;
          tx_n   = i_tx_byte;
        end
        // A host request-to-send needs the clock to have been pulled low first.
        if (clk_in && !data_in && seen_q) begin
          state_n   = ST_RX_SLOT;
          seen_n    = 1'b0;
          clk_drv_n = 1'b1;
        end else if (held_q && idle_q == IDLE_MAX) begin
          state_n    = ST_TX_SLOT;
          seen_n     = 1'b0;
          data_drv_n = ~tx_bit(tx_q, 4'd0);
        end
      end
      ST_TX_SLOT: begin
        if (slot_q == HP_LAST) begin
          if (!clk_in) begin
            // Host inhibit: drop the frame, keep the byte for a later retry.
            state_n    = ST_IDLE;
            clk_drv_n  = 1'b0;
            data_drv_n = 1'b0;
            idle_n     = '0;
          end else begin
            clk_drv_n = 1'b1;
          end
        end else if (slot_q == SL_LAST) begin
          clk_drv_n = 1'b0;
          if (bit_q == 4'd10) begin
            state_n    = ST_DONE;
            data_drv_n = 1'b0;
          end else begin
            bit_n      = bit_q + 4'd1;
            data_drv_n = ~tx_bit(tx_q, bit_q + 4'd1);
          end
        end
      end
      ST_DONE: begin
        done_n  = 1'b1;
        held_n  = 1'b0;
        idle_n  = '0;
        state_n = ST_IDLE;
      end
      ST_RX_SLOT: begin
        if (slot_q == HP_LAST) begin
          clk_drv_n = 1'b0;
        end else if (slot_q == RX_SAMP) begin
          rxs_n[bit_q] = data_in;
        end else if (slot_q == SL_LAST) begin
          if (bit_q == 4'd9) begin
            if (rxs_q[9]) begin
              state_n    = ST_RX_ACK;
              clk_drv_n  = 1'b1;
              data_drv_n = 1'b1;
            end else begin
              state_n = ST_IDLE;
              ferr_n  = 1'b1;
              idle_n  = '0;
            end
          end else begin
            bit_n     = bit_q + 4'd1;
            clk_drv_n = 1'b1;
          end
        end
      end
      ST_RX_ACK: begin
        if (slot_q == HP_LAST) begin
          clk_drv_n = 1'b0;
        end else if (slot_q == SL_LAST) begin
          data_drv_n = 1'b0;
          state_n    = ST_IDLE;
          idle_n     = '0;
          rxv_n      = 1'b1;
          rx_byte_n  = rxs_q[7:0];
          perr_n     = ~(^rxs_q[8:0]);
        end
      end
      default: state_n = ST_IDLE;
    endcase

    ready_n = (state_n == ST_IDLE) && !held_n;
  end

endmodule

// File: tb/tb_ps2_device_port.sv
// Directed bench for ps2_device_port: acts as the PS/2 host on the open-drain bus.
// Runs with shortened timing parameters so every frame fits in a small cycle budget.
module tb_ps2_device_port;
  localparam int HP  = 40;
  localparam int IH  = 50;
  localparam int FLT = 4;

  logic       clk, rst_n;
  wire        ps2_clk, ps2_data;
  logic       host_clk_low, host_data_low;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ready, tx_done, rx_valid, rx_perr, rx_ferr;
  logic [7:0] rx_byte;

  int n_cmp, n_bad, cyc;
  int done_cnt, rxv_cnt, ferr_cnt;
  logic overlap;

  pullup pu_clk (ps2_clk);
  pullup pu_data (ps2_data);
  assign ps2_clk  = host_clk_low  ? 1'b0 : 1'bz;
  assign ps2_data = host_data_low ? 1'b0 : 1'bz;

  ps2_device_port #(.HALF_PERIOD(HP), .IDLE_HOLD(IH), .FILTER(FLT)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .io_ps2_clk(ps2_clk), .io_ps2_data(ps2_data),
    .i_tx_byte(tx_byte), .i_tx_valid(tx_valid),
    .o_tx_ready(tx_ready), .o_tx_done(tx_done),
    .o_rx_byte(rx_byte), .o_rx_valid(rx_valid),
    .o_rx_parity_err(rx_perr), .o_rx_frame_err(rx_ferr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (tx_done)  done_cnt <= done_cnt + 1;
    if (rx_valid) rxv_cnt  <= rxv_cnt + 1;
    if (rx_ferr)  ferr_cnt <= ferr_cnt + 1;
    if (tx_done && rx_valid) overlap <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_edge(input logic rising, input int lim, output int t, output logic d, output logic ok);
    logic prev;
    ok = 1'b0; t = 0; d = 1'b0;
    prev = ps2_clk;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (rising ? (!prev && ps2_clk) : (prev && !ps2_clk)) begin
        t = cyc; d = ps2_data; ok = 1'b1;
        return;
      end
      prev = ps2_clk;
    end
  endtask

  task automatic send_req(input logic [7:0] b);
    @(negedge clk);
    for (int i = 0; i < 300 && !tx_ready; i++) @(negedge clk);
    chk("req_ready", 32'(tx_ready), 1);
    tx_byte = b; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("req_drop", 32'(tx_ready), 0);
  endtask

  task automatic capture_tx(input string tag, input logic [10:0] exp, input int base);
    logic [10:0] bits;
    int t, t0;
    logic d, ok;
    bit edges_ok, intv_ok;
    bits = '0; t0 = 0; edges_ok = 1'b1; intv_ok = 1'b1;
    for (int k = 0; k < 11; k++) begin
      wait_edge(1'b0, 400, t, d, ok);
      if (!ok) edges_ok = 1'b0;
      bits[k] = d;
      if (k > 0 && t - t0 != 2 * HP) intv_ok = 1'b0;
      t0 = t;
    end
    chk({tag, "_edges"}, 32'(edges_ok), 1);
    chk({tag, "_bits"}, 32'(bits), 32'(exp));
    chk({tag, "_period"}, 32'(intv_ok), 1);
    for (int i = 0; i < 300 && done_cnt == base; i++) @(negedge clk);
    repeat (100) @(negedge clk);
    chk({tag, "_done"}, done_cnt - base, 1);
  endtask

  task automatic host_send(input string tag, input logic [7:0] b, input logic par, input logic stop);
    logic [9:0] f;
    int t, rb, fb;
    logic d, ok;
    bit edges_ok;
    f = {stop, par, b}; edges_ok = 1'b1; rb = rxv_cnt; fb = ferr_cnt;
    host_clk_low = 1'b1;
    repeat (3 * HP) @(negedge clk);
    host_data_low = 1'b1;
    repeat (5) @(negedge clk);
    host_clk_low = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wait_edge(1'b0, 400, t, d, ok);
      if (!ok) edges_ok = 1'b0;
      host_data_low = !f[i];
    end
    if (stop) begin
      wait_edge(1'b0, 400, t, d, ok);
      if (!ok) edges_ok = 1'b0;
      repeat (HP / 2) @(negedge clk);
      chk({tag, "_ack"}, 32'(ps2_data), 0);
      for (int i = 0; i < 300 && rxv_cnt == rb; i++) @(negedge clk);
      chk({tag, "_valid"}, rxv_cnt - rb, 1);
    end else begin
      for (int i = 0; i < 300 && ferr_cnt == fb; i++) @(negedge clk);
      host_data_low = 1'b0;
      chk({tag, "_ferr"}, ferr_cnt - fb, 1);
      chk({tag, "_novalid"}, rxv_cnt - rb, 0);
    end
    chk({tag, "_edges"}, 32'(edges_ok), 1);
    repeat (20) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, t;
    logic d, ok;
    n_cmp = 0; n_bad = 0; cyc = 0;
    done_cnt = 0; rxv_cnt = 0; ferr_cnt = 0; overlap = 1'b0;
    host_clk_low = 1'b0; host_data_low = 1'b0;
    tx_byte = '0; tx_valid = 1'b0;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_clk_line", 32'(ps2_clk), 1);
    chk("rst_data_line", 32'(ps2_data), 1);
    chk("rst_ready", 32'(tx_ready), 0);
    chk("rst_outs", {26'd0, tx_done, rx_valid, rx_perr, rx_ferr, 2'b0}, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_ready", 32'(tx_ready), 1);

    // Plain transmit of 0x1C.
    base = done_cnt;
    send_req(8'h1C);
    capture_tx("tx1c", 11'h438, base);

    // Host inhibits during slot 4, then the whole frame is resent.
    base = done_cnt;
    send_req(8'h1C);
    for (int k = 0; k < 4; k++) wait_edge(1'b0, 400, t, d, ok);
    wait_edge(1'b1, 400, t, d, ok);
    repeat (10) @(negedge clk);
    host_clk_low = 1'b1;
    repeat (HP + 4) @(negedge clk);
    chk("inh_data_rel", 32'(ps2_data), 1);
    chk("inh_held", 32'(tx_ready), 0);
    repeat (2 * HP) @(negedge clk);
    host_clk_low = 1'b0;
    repeat (2) @(negedge clk);
    chk("inh_clk_rel", 32'(ps2_clk), 1);
    chk("inh_no_done", done_cnt - base, 0);
    capture_tx("retry", 11'h438, base);

    // Host commands.
    host_send("rx_ed", 8'hED, 1'b1, 1'b1);
    chk("rx_ed_byte", 32'(rx_byte), 32'h ED);
    chk("rx_ed_perr", 32'(rx_perr), 0);
    host_send("rx_02", 8'h02, 1'b1, 1'b1);
    chk("rx_02_byte", 32'(rx_byte), 32'h02);
    chk("rx_02_perr", 32'(rx_perr), 1);
    host_send("rx_ferr", 8'h55, 1'b0, 1'b0);
    chk("ferr_byte_kept", 32'(rx_byte), 32'h02);
    chk("ferr_perr_kept", 32'(rx_perr), 1);

    // TX request lands during a host RTS: receive first, then transmit.
    base = done_cnt;
    host_clk_low = 1'b1;
    repeat (20) @(negedge clk);
    send_req(8'hFA);
    host_send("rts", 8'hED, 1'b1, 1'b1);
    chk("rts_byte", 32'(rx_byte), 32'h ED);
    chk("rts_order", done_cnt - base, 0);
    capture_tx("txfa", 11'h7F4, base);

    // Reset in the middle of slot 6.
    base = done_cnt;
    send_req(8'h1C);
    for (int k = 0; k < 6; k++) wait_edge(1'b0, 400, t, d, ok);
    wait_edge(1'b1, 400, t, d, ok);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_clk", 32'(ps2_clk), 1);
    chk("mid_rst_data", 32'(ps2_data), 1);
    chk("mid_rst_outs", {22'd0, rx_byte, tx_ready, tx_done, rx_valid, rx_perr, rx_ferr, 1'b0}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_no_done", done_cnt - base, 0);
    base = done_cnt;
    send_req(8'h1C);
    capture_tx("after_rst", 11'h438, base);

    chk("no_overlap", 32'(overlap), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
